// File: rtl/dmem_copy_engine.sv
// Word-wide memory copy/fill engine driving a single-port memory with combinational read.
// Requests are bounds-checked before any access; copies proceed one word at a time, read before write.
module dmem_copy_engine #(
    parameter int DEPTH = 32,
    parameter int AW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [5:0]    length,
    input  logic [AW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_address,
    output logic [AW-1:0] mem_write_data,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [AW-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [AW-1:0] hold_q, hold_d;

    logic          mode_q, mode_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [5:0]    len_q, len_d;
    logic [AW-1:0] fill_q, fill_d;

    logic [AW:0]   len_x;
    logic [AW:0]   src_end;
    logic [AW:0]   dst_end;
    logic [AW-1:0] cnt_x;
    logic          req_bad;
    logic          last_word;

    // End addresses carry one extra bit so a huge base address cannot wrap into range.
    assign len_x     = {{(AW-5){1'b0}}, len_q};
    assign src_end   = {1'b0, src_q} + len_x;
    assign dst_end   = {1'b0, dst_q} + len_x;
    assign cnt_x     = {{(AW-6){1'b0}}, cnt_q};
    assign req_bad   = (len_x > DEPTH_X) || (dst_end > DEPTH_X) ||
                       (!mode_q && (src_end > DEPTH_X));
    assign last_word = ({1'b0, cnt_q} + 7'd1) == {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        src_q  <= src_d;
        dst_q  <= dst_d;
        len_q  <= len_d;
        fill_q <= fill_d;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hold_d         = hold_q;
        mode_d         = mode_q;
        src_d          = src_q;
        dst_d          = dst_q;
        len_d          = len_q;
        fill_d         = fill_q;
        busy           = 1'b1;
        done           = 1'b0;
        err            = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    mode_d  = mode;
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = length;
                    fill_d  = fill_value;
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end
            end

            // A zero-length request completes even if its addresses are out of range.
            S_CHECK: begin
                if (len_q == 6'd0) begin
                    state_d = S_FIN;
                end else if (req_bad) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = mode_q ? S_WRITE : S_READ;
                end
            end

            S_READ: begin
                mem_read    = 1'b1;
                mem_address = src_q + cnt_x;
                hold_d      = mem_read_data;
                state_d     = S_WRITE;
            end

            S_WRITE: begin
                mem_write      = 1'b1;
                mem_address    = dst_q + cnt_x;
                mem_write_data = mode_q ? fill_q : hold_q;
                cnt_d          = cnt_q + 6'd1;
                if (last_word) begin
                    state_d = S_FIN;
                end else begin
                    state_d = mode_q ? S_WRITE : S_READ;
                end
            end

            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: directed scenarios plus randomized requests
// checked against an array-level model of copy/fill and the documented completion latencies.
module tb_dmem_copy_engine;

    localparam int DEPTH = 32;
    localparam int AW    = 64;
    localparam logic [AW-1:0] DEPTH_A = 64'(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [5:0]    length = '0;
    logic [AW-1:0] fill_value = '0;
    logic          busy, done, err, mem_write, mem_read;
    logic [AW-1:0] mem_address, mem_write_data, mem_read_data;

    logic [AW-1:0] mem  [DEPTH];
    logic [AW-1:0] img  [DEPTH];
    logic [AW-1:0] refm [DEPTH];
    logic          load_img = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_copy_engine #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .fill_value     (fill_value),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    // Behavioural memory: synchronous write, combinational read, bulk image load.
    always @(posedge clk) begin
        if (load_img) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= img[k];
        end else if (mem_write && (mem_address < DEPTH_A)) begin
            mem[mem_address[4:0]] <= mem_write_data;
        end
    end

    always_comb begin
        mem_read_data = '0;
        if (mem_address < DEPTH_A) mem_read_data = mem[mem_address[4:0]];
    end

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_image();
        @(negedge clk);
        load_img = 1'b1;
        @(posedge clk);
        #1;
        load_img = 1'b0;
        for (int k = 0; k < DEPTH; k++) refm[k] = img[k];
    endtask

    task automatic set_base_image();
        for (int k = 0; k < DEPTH; k++) img[k] = (k < 5) ? 64'd5 : 64'd0;
        load_image();
    endtask

    task automatic set_random_image();
        for (int k = 0; k < DEPTH; k++) img[k] = {$urandom(), $urandom()};
        load_image();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ".rst_busy"},  64'(busy), 64'd0);
        check({name, ".rst_done"},  64'(done), 64'd0);
        check({name, ".rst_err"},   64'(err), 64'd0);
        check({name, ".rst_rd"},    64'(mem_read), 64'd0);
        check({name, ".rst_wr"},    64'(mem_write), 64'd0);
        check({name, ".rst_addr"},  mem_address, 64'd0);
        check({name, ".rst_wdata"}, mem_write_data, 64'd0);
    endtask

    // One request: model the expected memory and timing, drive it, observe every cycle.
    task automatic run_req(input string name, input logic md, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input logic [5:0] len,
                           input logic [AW-1:0] fv, input int rst_after, input bit poke);
        logic [AW-1:0] len_a;
        bit   bad;
        int   L, nwords, budget;
        int   exp_done, exp_err, exp_rd, exp_wr, exp_busy;
        int   got_done, got_err, n_done, n_err, n_rd, n_wr, n_busy;
        bit   conflict, stray, aborted;

        len_a = {58'd0, len};
        L     = int'(len);
        bad   = (len_a != 0) && ((len_a > DEPTH_A) || (dst > DEPTH_A - len_a) ||
                                 (!md && (src > DEPTH_A - len_a)));
        nwords = bad ? 0 : ((rst_after > 0) ? rst_after : L);
        for (int k = 0; k < nwords; k++) begin
            if (md) refm[int'(dst[5:0]) + k] = fv;
            else    refm[int'(dst[5:0]) + k] = refm[int'(src[5:0]) + k];
        end

        exp_err = 0; exp_rd = 0; exp_wr = 0;
        if (bad) begin
            exp_done = 0; exp_err = 1; exp_busy = 1;
        end else if (L == 0) begin
            exp_done = 2; exp_busy = 2;
        end else if (md) begin
            exp_done = L + 2; exp_busy = L + 2; exp_wr = L;
        end else begin
            exp_done = 2 * L + 2; exp_busy = 2 * L + 2; exp_rd = L; exp_wr = L;
        end
        if (rst_after > 0 && !bad) begin
            exp_done = 0; exp_wr = rst_after; exp_rd = rst_after + 1;
            exp_busy = 2 * rst_after + 2;
        end
        budget = (bad ? 1 : 2 * L + 2) + 3;

        got_done = 0; got_err = 0; n_done = 0; n_err = 0;
        n_rd = 0; n_wr = 0; n_busy = 0;
        conflict = 1'b0; stray = 1'b0; aborted = 1'b0;

        @(negedge clk);
        mode = md; src_addr = src; dst_addr = dst; length = len; fill_value = fv;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (poke && c == 3) begin
                start = 1'b1; mode = 1'b1; dst_addr = '0; length = 6'd1;
            end
            if (poke && c == 4) start = 1'b0;
            if (busy) n_busy++;
            if (done) begin n_done++; if (got_done == 0) got_done = c; end
            if (err)  begin n_err++;  if (got_err == 0)  got_err  = c; end
            if (mem_read)  n_rd++;
            if (mem_write) n_wr++;
            if (mem_read && mem_write) conflict = 1'b1;
            if (!mem_read && !mem_write && (mem_address != 0 || mem_write_data != 0)) stray = 1'b1;
            if (rst_after > 0 && n_wr == rst_after && !mem_write) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check_outputs_zero(name);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
        end

        check({name, ".done_cycle"}, 64'(got_done), 64'(exp_done));
        check({name, ".done_count"}, 64'(n_done), 64'((exp_done != 0) ? 1 : 0));
        check({name, ".err_cycle"},  64'(got_err), 64'(exp_err));
        check({name, ".err_count"},  64'(n_err), 64'(exp_err));
        check({name, ".reads"},      64'(n_rd), 64'(exp_rd));
        check({name, ".writes"},     64'(n_wr), 64'(exp_wr));
        check({name, ".busy_cycles"}, 64'(n_busy), 64'(exp_busy));
        check({name, ".rd_wr_overlap"}, 64'(conflict), 64'd0);
        check({name, ".idle_bus"},   64'(stray), 64'd0);
        check({name, ".rst_abort"},  64'(aborted), 64'((rst_after > 0 && !bad) ? 1 : 0));

        @(negedge clk);
        check({name, ".idle_after"}, 64'(busy), 64'd0);
        for (int w = 0; w < 200 && busy; w++) @(negedge clk);
        if (busy) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) check($sformatf("%s.mem[%0d]", name, k), mem[k], refm[k]);
    endtask

    initial begin
        // Reset with start held high: reset must win.
        rst = 1'b1; start = 1'b1; mode = 1'b1; length = 6'd3;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset.idle", 64'(busy), 64'd0);

        set_base_image();
        run_req("copy5", 1'b0, 64'd0, 64'd10, 6'd5, 64'd0, 0, 1'b0);
        set_base_image();
        run_req("len0", 1'b0, 64'd3, 64'd7, 6'd0, 64'd0, 0, 1'b0);
        set_base_image();
        run_req("err_src", 1'b0, 64'd30, 64'd0, 6'd4, 64'd0, 0, 1'b0);
        set_base_image();
        run_req("fill3", 1'b1, 64'd0, 64'd20, 6'd3, 64'hA5, 0, 1'b0);
        set_base_image();
        run_req("rst_mid", 1'b0, 64'd0, 64'd10, 6'd5, 64'd0, 2, 1'b0);
        set_base_image();
        run_req("poke", 1'b0, 64'd0, 64'd10, 6'd5, 64'd0, 0, 1'b1);
        set_base_image();
        run_req("overlap", 1'b0, 64'd0, 64'd1, 6'd4, 64'd0, 0, 1'b0);

        set_random_image();
        run_req("ovl_rand", 1'b0, 64'd2, 64'd3, 6'd6, 64'd0, 0, 1'b0);
        set_random_image();
        run_req("fill_full", 1'b1, 64'd0, 64'd0, 6'd32, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
        set_random_image();
        run_req("fill_33", 1'b1, 64'd0, 64'd0, 6'd33, 64'd7, 0, 1'b0);
        set_random_image();
        run_req("copy_edge", 1'b0, 64'd28, 64'd0, 6'd4, 64'd0, 0, 1'b0);
        set_random_image();
        run_req("dst_edge", 1'b1, 64'd0, 64'd29, 6'd4, 64'd9, 0, 1'b0);
        set_random_image();
        run_req("dst_wrap", 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 64'd9, 0, 1'b0);
        set_random_image();
        run_req("src_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 6'd3, 64'd0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic          md;
            logic [AW-1:0] s, d, f;
            logic [5:0]    l;
            md = 1'($urandom_range(0, 1));
            s  = 64'($urandom_range(0, 36));
            d  = 64'($urandom_range(0, 36));
            l  = 6'($urandom_range(0, 36));
            f  = {$urandom(), $urandom()};
            set_random_image();
            run_req($sformatf("rand%0d", t), md, s, d, l, f, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_copy_engine.md
DMEM_COPY_ENGINE -- requirements
Module: dmem_copy_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 64-bit words in the attached data memory.
REQ-002 SHALL have parameter AW, default 64, meaning the width of the address and data paths.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a request strobe, sampled in IDLE only.
REQ-006 SHALL have port mode, input, 1 bit: 0 = copy, 1 = fill; sampled with start.
REQ-007 SHALL have port src_addr, input, AW bits: first source word index (copy mode only).
REQ-008 SHALL have port dst_addr, input, AW bits: first destination word index.
REQ-009 SHALL have port length, input, 6 bits: word count, legal range 0..DEPTH.
REQ-010 SHALL have port fill_value, input, AW bits: the value written in fill mode.
REQ-011 SHALL have port busy, output, 1 bit: high while a request is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse on a rejected request.
REQ-014 SHALL have port mem_address, output, AW bits: word index driven to the memory.
REQ-015 SHALL have port mem_write_data, output, AW bits: write data to the memory.
REQ-016 SHALL have port mem_write, output, 1 bit: write strobe; the memory writes on the rising clk edge.
REQ-017 SHALL have port mem_read, output, 1 bit: read enable; the memory returns data combinationally.
REQ-018 SHALL have port mem_read_data, input, AW bits: read data from the memory, valid in the same cycle mem_read is high.

Function
REQ-019 SHALL implement states IDLE, CHECK, READ, WRITE, FIN.
REQ-020 SHALL, in IDLE with start=1, latch mode, src_addr, dst_addr, length and fill_value, clear word counter i, and go to CHECK.
REQ-021 SHALL, in CHECK, go to FIN if length=0, and perform no memory access in that case.
REQ-022 SHALL, in CHECK, reject the request by pulsing err for one cycle and returning to IDLE if length>DEPTH, dst_addr+length>DEPTH, or (mode=0 and src_addr+length>DEPTH); the sums SHALL be computed AW+1 bits wide so that no wrap-around occurs.
REQ-023 SHALL, in CHECK with a legal request, go to READ for mode 0 or to WRITE for mode 1.
REQ-024 SHALL, in READ, drive mem_read=1 and mem_address=src+i, capture mem_read_data into a holding register at the clock edge, and go to WRITE.
REQ-025 SHALL, in WRITE, drive mem_write=1, mem_address=dst+i, and mem_write_data equal to the holding register (mode 0) or fill_value (mode 1), then increment i.
REQ-026 SHALL, after WRITE, go to FIN if i+1=length; otherwise it SHALL go to READ (mode 0) or stay in WRITE (mode 1).
REQ-027 SHALL, in FIN, pulse done for one cycle and then return to IDLE.
REQ-028 SHALL, in IDLE, CHECK and FIN, drive mem_read=0, mem_write=0, mem_address=0 and mem_write_data=0; mem_read and mem_write SHALL never be high together.
REQ-029 SHALL hold busy=1 in CHECK, READ, WRITE and FIN, and busy=0 in IDLE.
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL meet these latencies, counted from the start edge: CHECK in cycle 1; copy done in cycle 2*length+2; fill done in cycle length+2; length-0 done in cycle 2; err in cycle 1.
REQ-032 SHALL copy in ascending word order, performing each word's read before its write; overlapping regions SHALL produce exactly that sequential result.

Reset
REQ-033 SHALL, while rst=1 at a clock edge, force the state to IDLE, i=0, the holding register to 0, and all outputs to 0 (busy, done, err, mem_read, mem_write, mem_address, mem_write_data).
REQ-034 SHALL, when rst is asserted mid-operation, issue no further mem_write after that edge; words already written SHALL stay written.
REQ-035 SHALL give rst priority over start in the same cycle.

Verification
REQ-036 Bench SHALL cover: mem[0..4]=5, rest 0; copy src=0 dst=10 len=5 -> mem[10..14]=5, mem[15]=0, done in cycle 12, exactly 5 read and 5 write strobes.
REQ-037 Bench SHALL cover: start with len=0 -> done in cycle 2, busy high for 2 cycles, no mem_read or mem_write.
REQ-038 Bench SHALL cover: copy src=30 len=4 -> err in cycle 1, no done, no strobes, memory unchanged.
REQ-039 Bench SHALL cover: fill dst=20 len=3 value=0xA5 -> mem[20..22]=0xA5, mem[23]=0, done in cycle 5, no mem_read.
REQ-040 Bench SHALL cover: copy src=0 dst=10 len=5, rst asserted after the second WRITE -> only mem[10..11]=5, mem[12..14]=0, all outputs 0 on the next edge.
REQ-041 Bench SHALL cover: a second start pulsed during an active copy -> ignored, one done only; overlapping copy src=0 dst=1 len=4 -> mem[1..4]=5 (ascending semantics).
